key_led_debounce_ctrl: RTL and testbench

- Parametrised successor to the board-level key-to-LED glue logic.
- Debounces N active-low push-buttons, generates press pulses, and drives LEDs in one of four switch-selected modes: direct/gate, toggle, up/down count, hold.
- Sits directly under the DE10-Nano top level, between the KEY/SW pins and the LED pins.

---
 rtl/key_led_debounce_ctrl.sv | 118 +++++++++++
 tb/tb_key_led_debounce_ctrl.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_led_debounce_ctrl.sv
// Key debouncer and LED mode controller for the DE10-Nano board.
// Synchronises and debounces active-low keys, emits press pulses, and drives LEDs in gate/toggle/count/hold modes.
module key_led_debounce_ctrl #(
    parameter int NUM_KEYS        = 2,
    parameter int NUM_LEDS        = 8,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic                FPGA_CLK1_50,
    input  logic                RESET_N,
    input  logic [NUM_KEYS-1:0] KEY,
    input  logic [1:0]          SW,
    output logic [NUM_LEDS-1:0] LED,
    output logic [NUM_KEYS-1:0] KEY_PRESSED,
    output logic [NUM_KEYS-1:0] KEY_PRESS_PULSE
);

    typedef enum logic [1:0] {
        MODE_GATE   = 2'b00,
        MODE_TOGGLE = 2'b01,
        MODE_COUNT  = 2'b10,
        MODE_HOLD   = 2'b11
    } mode_e;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [NUM_KEYS-1:0]            keyS1_q, keyS2_q;
    logic [1:0]                     swS1_q, swS2_q;
    logic [NUM_KEYS-1:0]            stable_q, stable_d;
    logic [NUM_KEYS-1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [NUM_KEYS-1:0]            pressed_q, pulse_q;
    logic [NUM_KEYS-1:0]            toggle_q, toggle_d;
    logic [NUM_LEDS-1:0]            count_q, count_d;
    logic [NUM_LEDS-1:0]            led_q, led_d;
    mode_e                          mode;

    assign mode = mode_e'(swS2_q);

    // A level is accepted only after it has differed from the stable level for DEBOUNCE_CYCLES samples in a row.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = cnt_q;
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (keyS2_q[i] == stable_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_LAST) begin
                stable_d[i] = keyS2_q[i];
                cnt_d[i]    = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
    end

    always_comb begin
        toggle_d = toggle_q;
        count_d  = count_q;
        led_d    = led_q;
        case (mode)
            MODE_GATE: begin
                led_d                 = '0;
                led_d[NUM_KEYS-1:0]   = pressed_q;
                led_d[NUM_KEYS+1]     = |pressed_q;
                led_d[NUM_KEYS+2]     = &pressed_q;
                led_d[NUM_KEYS+3]     = ^pressed_q;
            end
            MODE_TOGGLE: begin
                toggle_d            = toggle_q ^ pulse_q;
                led_d               = '0;
                led_d[NUM_KEYS-1:0] = toggle_d;
            end
            MODE_COUNT: begin
                if (pulse_q[0] && !pulse_q[1]) begin
                    count_d = count_q + 1'b1;
                end else if (!pulse_q[0] && pulse_q[1]) begin
                    count_d = count_q - 1'b1;
                end
                led_d = count_d;
            end
            MODE_HOLD: begin
            end
        endcase
    end

    // Pressed and pulse are registered from the stable level so they appear together, one edge after acceptance.
    always_ff @(posedge FPGA_CLK1_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            keyS1_q   <= '1;
            keyS2_q   <= '1;
            swS1_q    <= 2'b00;
            swS2_q    <= 2'b00;
            stable_q  <= '1;
            cnt_q     <= '0;
            pressed_q <= '0;
            pulse_q   <= '0;
            toggle_q  <= '0;
            count_q   <= '0;
            led_q     <= '0;
        end else begin
            keyS1_q   <= KEY;
            keyS2_q   <= keyS1_q;
            swS1_q    <= SW;
            swS2_q    <= swS1_q;
            stable_q  <= stable_d;
            cnt_q     <= cnt_d;
            pressed_q <= ~stable_q;
            pulse_q   <= ~stable_q & ~pressed_q;
            toggle_q  <= toggle_d;
            count_q   <= count_d;
            led_q     <= led_d;
        end
    end

    assign LED             = led_q;
    assign KEY_PRESSED     = pressed_q;
    assign KEY_PRESS_PULSE = pulse_q;

endmodule

// File: tb/tb_key_led_debounce_ctrl.sv
// Self-checking bench for key_led_debounce_ctrl with a sliding-window reference model.
// Directed scenarios follow the board test plan, then a randomized soak compares every cycle.
module tb_key_led_debounce_ctrl;

    localparam int D = 4;
    localparam int N = 2;
    localparam int L = 8;

    logic         clk = 1'b0;
    logic         rstN;
    logic [N-1:0] key;
    logic [1:0]   sw;
    logic [L-1:0] led;
    logic [N-1:0] keyPressed;
    logic [N-1:0] keyPulse;

    int checks = 0;
    int passed = 0;

    // Reference model: raw key samples per edge, SW samples per edge, and the visible results.
    logic [N-1:0] hist[$];
    logic [1:0]   swHist[$];
    logic [N-1:0] mStable, mStablePrev, mPressed, mPulse, mToggle;
    logic [L-1:0] mCount, mLed;

    always #10 clk = ~clk;

    key_led_debounce_ctrl #(
        .NUM_KEYS(N),
        .NUM_LEDS(L),
        .DEBOUNCE_CYCLES(D)
    ) dut (
        .FPGA_CLK1_50(clk),
        .RESET_N(rstN),
        .KEY(key),
        .SW(sw),
        .LED(led),
        .KEY_PRESSED(keyPressed),
        .KEY_PRESS_PULSE(keyPulse)
    );

    task automatic modelReset();
        hist.delete();
        swHist.delete();
        repeat (D + 2) hist.push_back({N{1'b1}});
        repeat (2) swHist.push_back(2'b00);
        mStable     = {N{1'b1}};
        mStablePrev = {N{1'b1}};
        mPressed    = '0;
        mPulse      = '0;
        mToggle     = '0;
        mCount      = '0;
        mLed        = '0;
    endtask

    // A key level is accepted once the D samples seen through the two-flop delay all agree.
    task automatic modelStep();
        logic [N-1:0] oldStable, oldPrev, oldPressed, oldPulse, newStable, sample;
        logic [1:0]   mode;
        bit           allLow, allHigh;
        oldStable  = mStable;
        oldPrev    = mStablePrev;
        oldPressed = mPressed;
        oldPulse   = mPulse;
        mode       = swHist[0];
        hist.push_back(key);
        void'(hist.pop_front());
        swHist.push_back(sw);
        void'(swHist.pop_front());
        newStable = oldStable;
        for (int i = 0; i < N; i++) begin
            allLow  = 1'b1;
            allHigh = 1'b1;
            for (int j = 0; j < D; j++) begin
                sample = hist[j];
                if (sample[i]) allLow = 1'b0;
                else           allHigh = 1'b0;
            end
            if (allLow)       newStable[i] = 1'b0;
            else if (allHigh) newStable[i] = 1'b1;
        end
        case (mode)
            2'b00: begin
                mLed = '0;
                for (int i = 0; i < N; i++) mLed[i] = oldPressed[i];
                mLed[N+1] = |oldPressed;
                mLed[N+2] = &oldPressed;
                mLed[N+3] = ^oldPressed;
            end
            2'b01: begin
                mToggle = mToggle ^ oldPulse;
                mLed    = '0;
                for (int i = 0; i < N; i++) mLed[i] = mToggle[i];
            end
            2'b10: begin
                if (oldPulse[0] && !oldPulse[1])      mCount = mCount + 8'd1;
                else if (!oldPulse[0] && oldPulse[1]) mCount = mCount - 8'd1;
                mLed = mCount;
            end
            default: begin
            end
        endcase
        mPressed    = ~oldStable;
        mPulse      = oldPrev & ~oldStable;
        mStablePrev = oldStable;
        mStable     = newStable;
    endtask

    // Advance n clock cycles, stepping the model on each rising edge; returns on a falling edge.
    task automatic applyStimulus(input int n);
        repeat (n) begin
            @(posedge clk);
            if (!rstN) modelReset();
            else       modelStep();
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rstN = 1'b0;
        key  = 2'b11;
        sw   = 2'b00;
        modelReset();
        applyStimulus(3);
        checks++;
        if ({led, keyPressed, keyPulse} !== '0)
            $display("[TB] FAIL reset_hold: got %h expected 0", {led, keyPressed, keyPulse});
        else passed++;
        rstN = 1'b1;
        for (int c = 0; c < 8; c++) begin
            applyStimulus(1);
            checks++;
            if ({led, keyPressed, keyPulse} !== {mLed, mPressed, mPulse})
                $display("[TB] FAIL reset_idle: got %h expected %h", {led, keyPressed, keyPulse}, {mLed, mPressed, mPulse});
            else passed++;
        end
        key = 2'b10;
        applyStimulus(10);
        checks++;
        if ({led, keyPressed} !== {8'h29, 2'b01})
            $display("[TB] FAIL reset_preload: got %h expected %h", {led, keyPressed}, {8'h29, 2'b01});
        else passed++;
        key = 2'b11;
        applyStimulus(3);
        #5 rstN = 1'b0;
        modelReset();
        #1;
        checks++;
        if ({led, keyPressed, keyPulse} !== '0)
            $display("[TB] FAIL reset_async: got %h expected 0", {led, keyPressed, keyPulse});
        else passed++;
        key = 2'b10;
        applyStimulus(2);
        rstN = 1'b1;
        for (int c = 0; c < 10; c++) begin
            applyStimulus(1);
            checks++;
            if ({led, keyPressed, keyPulse} !== {mLed, mPressed, mPulse})
                $display("[TB] FAIL reset_release: got %h expected %h", {led, keyPressed, keyPulse}, {mLed, mPressed, mPulse});
            else passed++;
        end
        checks++;
        if (keyPressed !== 2'b01)
            $display("[TB] FAIL reset_fresh_debounce: got %b expected 01", keyPressed);
        else passed++;
        key = 2'b11;
        applyStimulus(10);
    endtask

    task automatic test_gate();
        logic [N-1:0] keyPlan [3] = '{2'b10, 2'b00, 2'b11};
        logic [L-1:0] ledPlan [3] = '{8'h29, 8'h1B, 8'h00};
        int           pulsePlan [3] = '{1, 1, 0};
        int           pulses;
        sw = 2'b00;
        for (int p = 0; p < 3; p++) begin
            key    = keyPlan[p];
            pulses = 0;
            for (int c = 0; c < 10; c++) begin
                applyStimulus(1);
                checks++;
                if ({led, keyPressed, keyPulse} !== {mLed, mPressed, mPulse})
                    $display("[TB] FAIL gate_cycle: got %h expected %h", {led, keyPressed, keyPulse}, {mLed, mPressed, mPulse});
                else passed++;
                pulses += int'(keyPulse[0]) + int'(keyPulse[1]);
            end
            checks++;
            if (led !== ledPlan[p])
                $display("[TB] FAIL gate_led: got %h expected %h", led, ledPlan[p]);
            else passed++;
            checks++;
            if (pulses != pulsePlan[p])
                $display("[TB] FAIL gate_pulses: got %0d expected %0d", pulses, pulsePlan[p]);
            else passed++;
        end
    endtask

    task automatic test_bounce();
        logic [N-1:0] keyPlan [6] = '{2'b10, 2'b11, 2'b10, 2'b11, 2'b10, 2'b11};
        int           lenPlan [6] = '{3, 1, 3, 8, 10, 10};
        int           pulses = 0;
        bit           sawPress = 1'b0;
        sw = 2'b00;
        for (int p = 0; p < 6; p++) begin
            key = keyPlan[p];
            for (int c = 0; c < lenPlan[p]; c++) begin
                applyStimulus(1);
                checks++;
                if ({led, keyPressed, keyPulse} !== {mLed, mPressed, mPulse})
                    $display("[TB] FAIL bounce_cycle: got %h expected %h", {led, keyPressed, keyPulse}, {mLed, mPressed, mPulse});
                else passed++;
                pulses += int'(keyPulse[0]);
                sawPress |= keyPressed[0];
            end
            if (p == 3) begin
                checks++;
                if (sawPress || pulses != 0)
                    $display("[TB] FAIL bounce_reject: got press=%0d pulses=%0d expected 0 0", sawPress, pulses);
                else passed++;
            end
            if (p == 4) begin
                checks++;
                if (pulses != 1 || keyPressed !== 2'b01)
                    $display("[TB] FAIL bounce_accept: got pulses=%0d pressed=%b expected 1 01", pulses, keyPressed);
                else passed++;
            end
        end
    endtask

    task automatic test_toggle();
        logic [N-1:0] keyPlan [8] = '{2'b10, 2'b11, 2'b10, 2'b11, 2'b10, 2'b11, 2'b01, 2'b11};
        logic [L-1:0] ledPlan [8] = '{8'h01, 8'h01, 8'h00, 8'h00, 8'h01, 8'h01, 8'h03, 8'h03};
        key = 2'b11;
        sw  = 2'b01;
        applyStimulus(4);
        for (int p = 0; p < 8; p++) begin
            key = keyPlan[p];
            for (int c = 0; c < 10; c++) begin
                applyStimulus(1);
                checks++;
                if ({led, keyPressed, keyPulse} !== {mLed, mPressed, mPulse})
                    $display("[TB] FAIL toggle_cycle: got %h expected %h", {led, keyPressed, keyPulse}, {mLed, mPressed, mPulse});
                else passed++;
            end
            checks++;
            if (led !== ledPlan[p])
                $display("[TB] FAIL toggle_led: got %h expected %h", led, ledPlan[p]);
            else passed++;
        end
        sw = 2'b00;
        applyStimulus(6);
        checks++;
        if (led !== 8'h00)
            $display("[TB] FAIL toggle_leave: got %h expected 00", led);
        else passed++;
        sw = 2'b01;
        applyStimulus(2);
        checks++;
        if (led !== 8'h00)
            $display("[TB] FAIL toggle_sw_latency: got %h expected 00", led);
        else passed++;
        applyStimulus(1);
        checks++;
        if (led !== 8'h03)
            $display("[TB] FAIL toggle_restore: got %h expected 03", led);
        else passed++;
    endtask

    task automatic test_count();
        logic [N-1:0] keyPlan [16] = '{2'b01, 2'b11, 2'b10, 2'b11, 2'b10, 2'b11, 2'b00, 2'b11,
                                       2'b10, 2'b11, 2'b10, 2'b11, 2'b10, 2'b11, 2'b10, 2'b11};
        logic [L-1:0] ledPlan [16] = '{8'hFF, 8'hFF, 8'h00, 8'h00, 8'h01, 8'h01, 8'h01, 8'h01,
                                       8'h02, 8'h02, 8'h03, 8'h03, 8'h04, 8'h04, 8'h05, 8'h05};
        key  = 2'b11;
        rstN = 1'b0;
        modelReset();
        applyStimulus(2);
        rstN = 1'b1;
        sw   = 2'b10;
        applyStimulus(4);
        for (int p = 0; p < 16; p++) begin
            key = keyPlan[p];
            for (int c = 0; c < 10; c++) begin
                applyStimulus(1);
                checks++;
                if ({led, keyPressed, keyPulse} !== {mLed, mPressed, mPulse})
                    $display("[TB] FAIL count_cycle: got %h expected %h", {led, keyPressed, keyPulse}, {mLed, mPressed, mPulse});
                else passed++;
            end
            checks++;
            if (led !== ledPlan[p])
                $display("[TB] FAIL count_led: got %h expected %h", led, ledPlan[p]);
            else passed++;
        end
    endtask

    task automatic test_hold();
        logic [N-1:0] keyPlan [4] = '{2'b10, 2'b11, 2'b01, 2'b11};
        sw = 2'b11;
        applyStimulus(4);
        for (int p = 0; p < 4; p++) begin
            key = keyPlan[p];
            for (int c = 0; c < 10; c++) begin
                applyStimulus(1);
                checks++;
                if ({led, keyPressed, keyPulse} !== {mLed, mPressed, mPulse})
                    $display("[TB] FAIL hold_cycle: got %h expected %h", {led, keyPressed, keyPulse}, {mLed, mPressed, mPulse});
                else passed++;
            end
            checks++;
            if (led !== 8'h05)
                $display("[TB] FAIL hold_led: got %h expected 05", led);
            else passed++;
        end
        sw = 2'b10;
        applyStimulus(4);
        checks++;
        if (led !== 8'h05)
            $display("[TB] FAIL hold_return: got %h expected 05", led);
        else passed++;
        key = 2'b10;
        applyStimulus(10);
        checks++;
        if (led !== 8'h06)
            $display("[TB] FAIL hold_resume: got %h expected 06", led);
        else passed++;
        key = 2'b11;
        applyStimulus(10);
    endtask

    task automatic test_random();
        int cyc = 0;
        int n;
        while (cyc < 3000) begin
            key = N'($urandom);
            if ($urandom_range(0, 7) == 0) sw = 2'($urandom);
            if ($urandom_range(0, 99) == 0) rstN = 1'b0;
            n = $urandom_range(1, 2 * D + 4);
            for (int c = 0; c < n; c++) begin
                applyStimulus(1);
                rstN = 1'b1;
                checks++;
                if ({led, keyPressed, keyPulse} !== {mLed, mPressed, mPulse})
                    $display("[TB] FAIL random_cycle %0d: got %h expected %h", cyc, {led, keyPressed, keyPulse}, {mLed, mPressed, mPulse});
                else passed++;
                cyc++;
            end
        end
    endtask

    initial begin
        $display("[TB] starting key_led_debounce_ctrl bench");
        test_reset();
        test_gate();
        test_bounce();
        test_toggle();
        test_count();
        test_hold();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
